sdram_rom_loader: RTL and testbench

- Upstream feeder for the dual-port SDRAM controller.
- Converts the byte-wide ROM download stream into 16-bit write requests on the controller's two toggle-handshake request ports.
  - Port 1 serves the CPU banks (0,1).
  - Port 2 serves the graphics banks (2,3).
- Routes by byte address, packs byte pairs into words, emits partial-word writes via byte strobes, back-pressures the stream with ioctl_wait, and signals completion.

---
 rtl/sdram_rom_loader.sv | 187 ++++++++++++++++++
 tb/tb_sdram_rom_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_loader.sv
// Turns the byte-wide ROM download stream into 16-bit toggle-handshake write
// requests on two SDRAM controller ports (CPU banks on port 1, graphics on port 2).
module sdram_rom_loader #(
  parameter logic [24:0] PORT2_BASE = 25'h0100000,
  parameter logic [23:0] PORT2_OFFS = 24'h000000
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        p1_req,
  input  logic        p1_ack,
  output logic        p1_we,
  output logic [22:0] p1_a,
  output logic [1:0]  p1_ds,
  output logic [15:0] p1_d,
  output logic        p2_req,
  input  logic        p2_ack,
  output logic        p2_we,
  output logic [22:0] p2_a,
  output logic [1:0]  p2_ds,
  output logic [15:0] p2_d,
  output logic        busy,
  output logic        done,
  output logic [23:0] word_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_FINISH} state_t;

  // Handshake: a port is in flight while req != ack; the issuer toggles req with
  // a/ds/d in the same cycle and holds them until ack catches up.
  state_t      state_q, state_d;
  logic        dl_q;
  logic        skid_v_q, skid_v_d, skid_port_q, skid_port_d, skid_odd_q, skid_odd_d;
  logic [22:0] skid_wa_q, skid_wa_d;
  logic [7:0]  skid_dat_q, skid_dat_d;
  logic        pend_v_q, pend_v_d, pend_port_q, pend_port_d;
  logic [22:0] pend_wa_q, pend_wa_d;
  logic [7:0]  pend_dat_q, pend_dat_d;
  logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d;
  logic [22:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
  logic [1:0]  p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
  logic [15:0] p1_d_q, p1_d_d, p2_d_q, p2_d_d;
  logic        wait_q, wait_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [23:0] wcnt_q, wcnt_d;

  logic        live_port, p1_busy, p2_busy, active;
  logic [24:0] p2_rel;
  logic [23:0] live_ba;
  logic        cur_v, cur_port, cur_odd, pend_match;
  logic [22:0] cur_wa;
  logic [7:0]  cur_dat;
  logic        iss_v, iss_port, grant, g_consume, g_clr, g_set, consumed;
  logic [22:0] iss_wa;
  logic [1:0]  iss_ds;
  logic [15:0] iss_d;

  always_comb begin
    live_port = (ioctl_addr >= PORT2_BASE);
    p2_rel    = ioctl_addr - PORT2_BASE;
    live_ba   = live_port ? (p2_rel[23:0] + PORT2_OFFS) : ioctl_addr[23:0];
  end

  always_comb begin
    state_d = state_q;
    skid_v_d = skid_v_q; skid_port_d = skid_port_q; skid_odd_d = skid_odd_q;
    skid_wa_d = skid_wa_q; skid_dat_d = skid_dat_q;
    pend_v_d = pend_v_q; pend_port_d = pend_port_q; pend_wa_d = pend_wa_q; pend_dat_d = pend_dat_q;
    p1_req_d = p1_req_q; p1_a_d = p1_a_q; p1_ds_d = p1_ds_q; p1_d_d = p1_d_q;
    p2_req_d = p2_req_q; p2_a_d = p2_a_q; p2_ds_d = p2_ds_q; p2_d_d = p2_d_q;
    wcnt_d = wcnt_q;
    ovf_d  = ovf_q;
    p1_busy = (p1_req_q != p1_ack);
    p2_busy = (p2_req_q != p2_ack);
    active  = (state_q == S_LOAD) || (state_q == S_FLUSH);

    // The skid byte is older than any live strobe, so it is always served first.
    cur_v = 1'b0; cur_port = skid_port_q; cur_odd = skid_odd_q;
    cur_wa = skid_wa_q; cur_dat = skid_dat_q;
    if (active && skid_v_q) begin
      cur_v = 1'b1;
    end else if (active && ioctl_wr) begin
      cur_v = 1'b1; cur_port = live_port; cur_odd = live_ba[0];
      cur_wa = live_ba[23:1]; cur_dat = ioctl_dout;
    end
    pend_match = pend_v_q && (pend_wa_q == cur_wa) && (pend_port_q == cur_port);

    iss_v = 1'b0; iss_port = pend_port_q; iss_wa = pend_wa_q;
    iss_ds = 2'b01; iss_d = {8'h00, pend_dat_q};
    g_consume = 1'b0; g_clr = 1'b0; g_set = 1'b0; consumed = 1'b0;
    if (cur_v) begin
      if (!cur_odd) begin
        if (pend_v_q && !pend_match) begin
          iss_v = 1'b1; g_set = 1'b1; g_consume = 1'b1;
        end else begin
          pend_v_d = 1'b1; pend_port_d = cur_port; pend_wa_d = cur_wa; pend_dat_d = cur_dat;
          consumed = 1'b1;
        end
      end else if (pend_match) begin
        iss_v = 1'b1; iss_ds = 2'b11; iss_d = {cur_dat, pend_dat_q};
        g_clr = 1'b1; g_consume = 1'b1;
      end else if (pend_v_q) begin
        // Unrelated low byte goes out first; this odd byte is retried next cycle.
        iss_v = 1'b1; g_clr = 1'b1;
      end else begin
        iss_v = 1'b1; iss_port = cur_port; iss_wa = cur_wa;
        iss_ds = 2'b10; iss_d = {cur_dat, 8'h00}; g_consume = 1'b1;
      end
    end else if (state_q == S_FLUSH && pend_v_q) begin
      iss_v = 1'b1; g_clr = 1'b1;
    end

    grant = iss_v && !(iss_port ? p2_busy : p1_busy);
    if (grant) begin
      wcnt_d = wcnt_q + 24'd1;
      if (iss_port) begin
        p2_req_d = ~p2_req_q; p2_a_d = iss_wa; p2_ds_d = iss_ds; p2_d_d = iss_d;
      end else begin
        p1_req_d = ~p1_req_q; p1_a_d = iss_wa; p1_ds_d = iss_ds; p1_d_d = iss_d;
      end
      if (g_clr) pend_v_d = 1'b0;
      if (g_set) begin
        pend_v_d = 1'b1; pend_port_d = cur_port; pend_wa_d = cur_wa; pend_dat_d = cur_dat;
      end
      consumed = g_consume;
    end

    if (skid_v_q) begin
      if (consumed) skid_v_d = 1'b0;
      if (active && ioctl_wr) begin
        if (consumed) begin
          skid_v_d = 1'b1; skid_port_d = live_port; skid_odd_d = live_ba[0];
          skid_wa_d = live_ba[23:1]; skid_dat_d = ioctl_dout;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end else if (cur_v && !consumed) begin
      skid_v_d = 1'b1; skid_port_d = cur_port; skid_odd_d = cur_odd;
      skid_wa_d = cur_wa; skid_dat_d = cur_dat;
    end

    case (state_q)
      S_IDLE:   if (ioctl_download && !dl_q) begin state_d = S_LOAD; wcnt_d = 24'd0; end
      S_LOAD:   if (!ioctl_download) state_d = S_FLUSH;
      S_FLUSH:  if (!cur_v && !pend_v_q && !p1_busy && !p2_busy) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    wait_d = skid_v_d;
    busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= S_IDLE; dl_q <= 1'b0;
      skid_v_q <= 1'b0; skid_port_q <= 1'b0; skid_odd_q <= 1'b0; skid_wa_q <= '0; skid_dat_q <= '0;
      pend_v_q <= 1'b0; pend_port_q <= 1'b0; pend_wa_q <= '0; pend_dat_q <= '0;
      p1_req_q <= 1'b0; p1_a_q <= '0; p1_ds_q <= '0; p1_d_q <= '0;
      p2_req_q <= 1'b0; p2_a_q <= '0; p2_ds_q <= '0; p2_d_q <= '0;
      wait_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; ovf_q <= 1'b0; wcnt_q <= '0;
    end else begin
      state_q <= state_d; dl_q <= ioctl_download;
      skid_v_q <= skid_v_d; skid_port_q <= skid_port_d; skid_odd_q <= skid_odd_d;
      skid_wa_q <= skid_wa_d; skid_dat_q <= skid_dat_d;
      pend_v_q <= pend_v_d; pend_port_q <= pend_port_d; pend_wa_q <= pend_wa_d; pend_dat_q <= pend_dat_d;
      p1_req_q <= p1_req_d; p1_a_q <= p1_a_d; p1_ds_q <= p1_ds_d; p1_d_q <= p1_d_d;
      p2_req_q <= p2_req_d; p2_a_q <= p2_a_d; p2_ds_q <= p2_ds_d; p2_d_q <= p2_d_d;
      wait_q <= wait_d; busy_q <= busy_d; done_q <= done_d; ovf_q <= ovf_d; wcnt_q <= wcnt_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign p1_req = p1_req_q; assign p1_we = 1'b1; assign p1_a = p1_a_q;
  assign p1_ds = p1_ds_q; assign p1_d = p1_d_q;
  assign p2_req = p2_req_q; assign p2_we = 1'b1; assign p2_a = p2_a_q;
  assign p2_ds = p2_ds_q; assign p2_d = p2_d_q;
  assign busy = busy_q;
  assign done = done_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Bench for sdram_rom_loader: byte-stream driver, two ack responders and a
// per-port expected-word scoreboard fed by a byte-level packing model.
module tb_sdram_rom_loader;
  localparam logic [24:0] BASE = 25'h0100000;
  localparam logic [23:0] OFFS = 24'h000000;

  logic        clk = 1'b0;
  logic        init_n = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        p1_ack = 1'b0, p2_ack = 1'b0;
  logic        ioctl_wait, p1_req, p1_we, p2_req, p2_we, busy, done;
  logic [22:0] p1_a, p2_a;
  logic [1:0]  p1_ds, p2_ds;
  logic [15:0] p1_d, p2_d;
  logic [23:0] word_count;

  sdram_rom_loader #(.PORT2_BASE(BASE), .PORT2_OFFS(OFFS)) dut (
    .clk(clk), .init_n(init_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .p1_req(p1_req), .p1_ack(p1_ack), .p1_we(p1_we), .p1_a(p1_a), .p1_ds(p1_ds), .p1_d(p1_d),
    .p2_req(p2_req), .p2_ack(p2_ack), .p2_we(p2_we), .p2_a(p2_a), .p2_ds(p2_ds), .p2_d(p2_d),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_fail = 0;
  logic [40:0] exp_q1[$], exp_q2[$];
  int          lat_lo[2], lat_hi[2], n_req[2];
  logic [40:0] last_cap[2];
  bit          m_pv, m_pport, saw_wait;
  logic [22:0] m_pwa;
  logic [7:0]  m_pdat;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference model: {word_addr, ds, data} expected per port, in issue order.
  task automatic model_push(input bit port, input logic [22:0] wa, input logic [1:0] ds,
                            input logic [15:0] d);
    if (port) exp_q2.push_back({wa, ds, d});
    else      exp_q1.push_back({wa, ds, d});
    m_cnt++;
  endtask

  task automatic model_byte(input logic [24:0] addr, input logic [7:0] dat);
    bit port; logic [24:0] rel; logic [23:0] ba; bit same;
    port = (addr >= BASE);
    rel  = addr - BASE;
    ba   = port ? (rel[23:0] + OFFS) : addr[23:0];
    same = m_pv && (m_pwa == ba[23:1]) && (m_pport == port);
    if (ba[0] == 1'b0) begin
      if (m_pv && !same) model_push(m_pport, m_pwa, 2'b01, {8'h00, m_pdat});
      m_pv = 1; m_pport = port; m_pwa = ba[23:1]; m_pdat = dat;
    end else if (same) begin
      model_push(port, ba[23:1], 2'b11, {dat, m_pdat});
      m_pv = 0;
    end else begin
      if (m_pv) model_push(m_pport, m_pwa, 2'b01, {8'h00, m_pdat});
      m_pv = 0;
      model_push(port, ba[23:1], 2'b10, {dat, 8'h00});
    end
  endtask

  task automatic model_flush();
    if (m_pv) model_push(m_pport, m_pwa, 2'b01, {8'h00, m_pdat});
    m_pv = 0;
  endtask

  // Controller stand-in: sees a toggle, checks the word, acks after a latency.
  task automatic responder(input int p);
    logic [40:0] got, cap, e;
    logic rq, ak, we;
    int cnt;
    bit infl;
    infl = 0; cnt = 0; cap = '0;
    forever begin
      @(negedge clk);
      if (p == 0) begin got = {p1_a, p1_ds, p1_d}; rq = p1_req; ak = p1_ack; we = p1_we; end
      else        begin got = {p2_a, p2_ds, p2_d}; rq = p2_req; ak = p2_ack; we = p2_we; end
      if (!init_n) begin
        infl = 0;
        if (p == 0) p1_ack = 1'b0; else p2_ack = 1'b0;
      end else if (!infl) begin
        if (rq != ak) begin
          infl = 1; cap = got; n_req[p]++; last_cap[p] = got;
          cnt = $urandom_range(lat_hi[p], lat_lo[p]);
          chk($sformatf("p%0d_we", p + 1), we, 1);
          if (p == 0) begin
            chk("p1_has_exp", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); chk("p1_word", got, e); end
          end else begin
            chk("p2_has_exp", exp_q2.size() > 0, 1);
            if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); chk("p2_word", got, e); end
          end
        end
      end else if (cnt <= 0) begin
        chk($sformatf("p%0d_stable", p + 1), got, cap);
        if (p == 0) p1_ack = rq; else p2_ack = rq;
        infl = 0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit drop);
    int guard;
    guard = 0;
    model_byte(a, d);
    if (drop) model_flush();
    while (ioctl_wait === 1'b1 && guard < 400) begin
      saw_wait = 1; ioctl_wr = 1'b0; @(posedge clk); #1; guard++;
    end
    chk("wait_bound", guard < 400, 1);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (drop) ioctl_download = 1'b0;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    if (ioctl_wait) saw_wait = 1;
  endtask

  task automatic start_dl();
    m_cnt = 0; m_pv = 0;
    ioctl_download = 1'b1;
    cycle(1);
    chk("busy_load", busy, 1);
  endtask

  task automatic finish_dl(input string tag);
    int pulses;
    pulses = 0;
    if (ioctl_download) begin model_flush(); ioctl_download = 1'b0; end
    for (int i = 0; i < 3000; i++) begin
      cycle(1);
      if (done) begin pulses++; break; end
    end
    repeat (5) begin cycle(1); if (done) pulses++; end
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_word_count"}, word_count, m_cnt);
    chk({tag, "_q1_empty"}, exp_q1.size(), 0);
    chk({tag, "_q2_empty"}, exp_q2.size(), 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_ovf"}, dut.ovf_q, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, len, kind, sel;
    logic [24:0] a;
    lat_lo[0] = 0; lat_hi[0] = 0; lat_lo[1] = 0; lat_hi[1] = 0;
    n_req[0] = 0; n_req[1] = 0;
    fork
      responder(0);
      responder(1);
    join_none

    #2 init_n = 1'b0;
    cycle(2);
    chk("rst_p1_req", p1_req, 0);      chk("rst_p2_req", p2_req, 0);
    chk("rst_p1_ds", p1_ds, 0);        chk("rst_p1_d", p1_d, 0);
    chk("rst_p1_a", p1_a, 0);          chk("rst_p2_a", p2_a, 0);
    chk("rst_p1_we", p1_we, 1);        chk("rst_wait", ioctl_wait, 0);
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_wcount", word_count, 0);
    init_n = 1'b1;
    cycle(2);

    // Contiguous 4 bytes to address 0.
    lat_lo[0] = 2; lat_hi[0] = 2;
    start_dl();
    send_byte(25'h0, 8'h11, 0); send_byte(25'h1, 8'h22, 0);
    send_byte(25'h2, 8'h33, 0); send_byte(25'h3, 8'h44, 0);
    finish_dl("t1");
    chk("t1_wcount_2", word_count, 2);
    chk("t1_last", last_cap[0], {23'd1, 2'b11, 16'h4433});

    // Route split around the port-2 base.
    n0 = n_req[0]; n1 = n_req[1];
    start_dl();
    send_byte(25'h0FFFFE, 8'h01, 0); send_byte(25'h0FFFFF, 8'h02, 0);
    send_byte(25'h100000, 8'h03, 0); send_byte(25'h100001, 8'h04, 0);
    finish_dl("t2");
    chk("t2_p1_toggles", n_req[0] - n0, 1);
    chk("t2_p2_toggles", n_req[1] - n1, 1);
    chk("t2_p1_addr", last_cap[0][40:18], 23'h7FFFF);
    chk("t2_p2_addr", last_cap[1][40:18], 23'h0);

    // Odd-length download: last byte at 0x04 needs the flush.
    start_dl();
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'h50 + i), 0);
    send_byte(25'h4, 8'hAB, 0);
    finish_dl("t3");
    chk("t3_flush_word", last_cap[0], {23'd2, 2'b01, 16'h00AB});

    // Non-contiguous pair.
    start_dl();
    send_byte(25'h10, 8'h5A, 0); send_byte(25'h21, 8'hA5, 0);
    finish_dl("t4");
    chk("t4_last", last_cap[0], {23'h10, 2'b10, 16'hA500});

    // Slow ack with a back-to-back stream.
    lat_lo[0] = 19; lat_hi[0] = 19; saw_wait = 0;
    start_dl();
    for (int i = 0; i < 8; i++) send_byte(25'(25'h200 + i), 8'($urandom_range(0, 255)), 0);
    finish_dl("t5");
    chk("t5_wait_seen", saw_wait, 1);

    // Falling edge of download together with the final strobe.
    lat_lo[0] = 1; lat_hi[0] = 3;
    start_dl();
    send_byte(25'h300, 8'hC0, 0); send_byte(25'h301, 8'hC1, 0);
    send_byte(25'h302, 8'hC2, 1);
    finish_dl("t6");
    chk("t6_last", last_cap[0], {23'h181, 2'b01, 16'h00C2});

    // Randomized downloads with mixed runs, ports, latencies and gaps.
    for (int dl = 0; dl < 8; dl++) begin
      lat_lo[0] = 0; lat_hi[0] = $urandom_range(0, 8);
      lat_lo[1] = 0; lat_hi[1] = $urandom_range(0, 8);
      start_dl();
      for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
        kind = $urandom_range(0, 2);
        case (kind)
          0: a = 25'($urandom_range(0, 'hFFF));
          1: a = 25'(25'h0FFFF0 + $urandom_range(0, 31));
          default: a = 25'(25'h100000 + $urandom_range(0, 'hFFFF));
        endcase
        len = $urandom_range(1, 10);
        for (int k = 0; k < len; k++) begin
          sel = $urandom_range(0, 3);
          send_byte(25'(a + 25'(k)), 8'($urandom_range(0, 255)), 0);
          if (sel == 0) cycle($urandom_range(1, 3));
        end
      end
      if ($urandom_range(0, 1) == 1) send_byte(25'(25'h180 + $urandom_range(0, 7)), 8'h3C, 1);
      finish_dl($sformatf("rnd%0d", dl));
    end

    // Reset while a port-1 word is in flight.
    lat_lo[0] = 30; lat_hi[0] = 30;
    start_dl();
    send_byte(25'h40, 8'h11, 0); send_byte(25'h41, 8'h22, 0);
    cycle(3);
    #2 init_n = 1'b0;
    #1;
    chk("mid_rst_p1_req", p1_req, 0);  chk("mid_rst_p1_ds", p1_ds, 0);
    chk("mid_rst_p1_d", p1_d, 0);      chk("mid_rst_p1_a", p1_a, 0);
    chk("mid_rst_busy", busy, 0);      chk("mid_rst_wcount", word_count, 0);
    chk("mid_rst_wait", ioctl_wait, 0);
    ioctl_download = 1'b0;
    exp_q1.delete(); exp_q2.delete(); m_pv = 0;
    cycle(2);
    init_n = 1'b1;
    n0 = n_req[0] + n_req[1];
    n1 = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1);
      if (done || p1_req || p2_req) n1++;
    end
    chk("post_rst_quiet", n1, 0);
    chk("post_rst_no_req", n_req[0] + n_req[1] - n0, 0);

    // Normal operation after the reset.
    lat_lo[0] = 1; lat_hi[0] = 1;
    start_dl();
    send_byte(25'h0, 8'hAA, 0); send_byte(25'h1, 8'hBB, 0);
    finish_dl("t8");
    chk("t8_word", last_cap[0], {23'd0, 2'b11, 16'hBBAA});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
